uc_min_queue: RTL
=================

Name: uc_min_queue

Overview:
- Per-engine UCQ_IN: a sorted buffer of implied unit-clause literals produced by one BCP engine.
- Presents its minimum-variable literal to the unit-clause arbiter wrapper as eng2uca_min/valid/empty and accepts pops from it.
- One instance per engine, between the engine's implication output and the arbiter.
- Insertion sort over a register array gives the arbiter's PQ mode a deterministic min-first stream.

Parameters:
- DEPTH, 8, number of literal slots; power of two, at least 2.
- LIT_W, $bits(lit_t), literal width taken from the shared package.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (queue cleared while low).
- eng_push  in  1  engine offers an implied literal this cycle.
- eng_lit  in  LIT_W  implied literal; MSB = polarity, low bits = variable index.
- uca_pop  in  1  arbiter consumes the head (this engine's uca2eng_pop bit).
- flush  in  1  backtrack/restart; empties the queue and clears the sticky flags.
- eng2uca_min  out  LIT_W  head literal (smallest variable index).
- eng2uca_valid  out  1  head is valid.
- eng2uca_empty  out  1  no entries.
- q_full  out  1  count == DEPTH; feeds eng2uca_full.
- q_count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky: a push was dropped.
- conflict  out  1  sticky: opposite-polarity literal seen (dedup build only).

Behaviour:
- Reset (rst low, async) and flush (sync, highest priority): all slots invalid, count=0, overflow=0, conflict=0. Outputs then read min=0, valid=0, empty=1, full=0.
- Storage: slot[0..DEPTH-1] is sorted ascending by variable index; slot[0] is the head. All outputs are driven from registers only, no combinational path from any input.
- Push latency: a literal pushed at edge N appears at the head from cycle N+1 if it is the smallest.
- Pop only (queue non-empty): slots shift down by one; count-1. Pop when empty: ignored, no flag.
- Push only (not full): the literal is inserted at the first slot whose index is greater; later slots shift up. On equal variable indices the new literal goes after the existing ones (FIFO among ties).
- Push and pop together: the current head is removed first, then the new literal is inserted into the remainder; count is unchanged. This is legal when full.
- Push when full without pop: literal dropped, overflow set, contents unchanged.
- Width and compare rules: unsigned compare on the index field only; the polarity bit is ignored for ordering.
- No internal state machine beyond the slot array, the count and the two sticky flags.

Optional Feature:
- Macro: UCQ_DEDUP_EN.
- With the macro, each push is compared against every valid slot, including a head popped in the same cycle.
  - Same variable, same polarity: push discarded, no count change, no overflow.
  - Same variable, opposite polarity: push discarded and conflict set (sticky until flush or reset).
- Without the macro, duplicates are stored like any other literal and conflict is tied to 0.

Decomposition:
- Package (shared): lit_t, LIT_IDX_MAX, NUM_ENGINE, helper function lit_var(lit_t) returning the index field.
- Sub-module: uc_insert_slot, one per slot. Inputs: own value, lower neighbour, upper neighbour, new literal, compare results. Output: the slot's next value. uc_min_queue instantiates DEPTH of them via generate.

Test Plan:
- Reset with rst low mid-stream while holding 3 entries -> empty=1, valid=0, count=0, flags 0, asynchronously.
- Push vars 5, 2, 9, 2' (second literal with index 2) on consecutive cycles, then pop 4 times -> pops return 2, 2', 5, 9 in that order; empty=1 after the last pop.
- Fill to DEPTH=8, push var 1 without pop -> overflow=1, count stays 8, head unchanged. Then push 1 and pop together -> old head removed, head becomes 1, count 8.
- Pop on empty queue -> no change, valid=0, no flag.
- UCQ_DEDUP_EN build: push +7 then +7 -> count 1. Push -7 -> conflict=1, count 1. Flush -> conflict=0, count 0.
- Flush asserted in the same cycle as push and pop -> queue empty next cycle, pushed literal not stored.

Source files
------------

// File: rtl/uc_min_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uc_min_queue_pkg
// Description : Shared literal types and helpers for the unit-clause queues.
//               A literal is {polarity, variable index}: MSB = polarity,
//               low VAR_W bits = variable index.
// Revision    : 1.0 - initial release
// ============================================================================
package uc_min_queue_pkg;

    localparam int unsigned VAR_W       = 8;
    localparam int unsigned NUM_ENGINE  = 4;
    localparam int unsigned LIT_IDX_MAX = (1 << VAR_W) - 1;

    typedef logic [VAR_W:0]   lit_t;
    typedef logic [VAR_W-1:0] var_t;

    // Variable index field; the only field used for ordering.
    function automatic var_t lit_var(input lit_t lit);
        return lit[VAR_W-1:0];
    endfunction

    // Polarity bit.
    function automatic logic lit_pol(input lit_t lit);
        return lit[VAR_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uc_insert_slot.sv
`default_nettype none
// ============================================================================
// Module      : uc_insert_slot
// Description : Next-value selector for one slot of the sorted literal queue.
//               The queue first (optionally) removes the head, which shifts
//               every slot down by one, and then (optionally) inserts a new
//               literal, which shifts the slots at and above the insertion
//               point up by one. Both shifts are folded into one mux here.
// Ports       : slot_own_i    - this slot's current value
//               slot_lower_i  - current value of slot i-1 (0 for slot 0)
//               slot_upper_i  - current value of slot i+1 (0 for last slot)
//               new_lit_i     - literal being inserted
//               pop_i         - head is removed this cycle
//               ins_i         - new literal is inserted this cycle
//               place_self_i  - new literal belongs at or below this slot
//               place_lower_i - new literal belongs at or below slot i-1
//               valid_next_i  - this slot holds an entry next cycle
//               slot_o        - next value of this slot (0 when unused)
// Revision    : 1.0 - initial release
// ============================================================================
module uc_insert_slot
    import uc_min_queue_pkg::*;
(
    input  lit_t slot_own_i,
    input  lit_t slot_lower_i,
    input  lit_t slot_upper_i,
    input  lit_t new_lit_i,
    input  logic pop_i,
    input  logic ins_i,
    input  logic place_self_i,
    input  logic place_lower_i,
    input  logic valid_next_i,
    output lit_t slot_o
);

    lit_t w_val;

    // Place flags are evaluated on the post-pop remainder, where the
    // remainder's slot i is slot_upper_i and its slot i-1 is slot_own_i.
    always_comb begin
        w_val = pop_i ? slot_upper_i : slot_own_i;
        if (ins_i && place_self_i) begin
            if (!place_lower_i) begin
                w_val = new_lit_i;
            end else begin
                w_val = pop_i ? slot_own_i : slot_lower_i;
            end
        end
        // Unused slots are held at zero so an empty queue reads min = 0.
        slot_o = valid_next_i ? w_val : '0;
    end

endmodule
`default_nettype wire

// File: rtl/uc_min_queue.sv
`default_nettype none
// ============================================================================
// Module      : uc_min_queue
// Description : Per-engine sorted buffer of implied unit-clause literals.
//               Keeps literals ascending by variable index (ties in arrival
//               order) and presents the smallest to the unit-clause arbiter.
//               Pop removes the head before a same-cycle push is inserted.
// Ports       : clk, rst (async, active-low)
//               eng_push/eng_lit  - literal offered by the BCP engine
//               uca_pop           - arbiter consumes the head
//               flush             - synchronous clear of queue and flags
//               eng2uca_min/valid/empty, q_full, q_count - queue status
//               overflow          - sticky, a push was dropped while full
//               conflict          - sticky, opposite-polarity duplicate seen
// Options     : UCQ_DEDUP_EN - drop pushes whose variable is already queued
//               and flag a conflict on opposite polarity. Without it,
//               duplicates are stored and conflict is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_min_queue
    import uc_min_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LIT_W = $bits(lit_t)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   eng_push,
    input  logic [LIT_W-1:0]       eng_lit,
    input  logic                   uca_pop,
    input  logic                   flush,
    output logic [LIT_W-1:0]       eng2uca_min,
    output logic                   eng2uca_valid,
    output logic                   eng2uca_empty,
    output logic                   q_full,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   overflow,
    output logic                   conflict
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    lit_t             slot_q [DEPTH];
    lit_t             slot_d [DEPTH];
    lit_t             rem    [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_rem;
    logic             overflow_q;
    logic             pop_eff;
    logic             dup_hit;
    logic             drop_full;
    logic             ins_en;
    logic [DEPTH-1:0] place;
    logic [DEPTH-1:0] valid_next;
    lit_t             new_lit;

    assign new_lit = eng_lit;

`ifdef UCQ_DEDUP_EN
    logic conflict_q;
    logic dup_conf;

    // Duplicate check runs against the contents before the pop, so a head
    // popped in the same cycle still suppresses a matching push.
    always_comb begin
        dup_hit  = 1'b0;
        dup_conf = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (eng_push && (CNT_W'(i) < count_q) &&
                (lit_var(slot_q[i]) == lit_var(new_lit))) begin
                dup_hit = 1'b1;
                if (lit_pol(slot_q[i]) != lit_pol(new_lit)) begin
                    dup_conf = 1'b1;
                end
            end
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    always_comb begin
        pop_eff   = uca_pop && (count_q != '0);
        count_rem = count_q - CNT_W'(pop_eff);
        drop_full = eng_push && !dup_hit && (count_rem == CNT_W'(DEPTH));
        ins_en    = eng_push && !dup_hit && !drop_full;
        count_d   = count_rem + CNT_W'(ins_en);

        // Remainder after the head is removed; used only to locate the
        // insertion point.
        for (int i = 0; i < DEPTH; i++) begin
            rem[i] = slot_q[i];
        end
        if (pop_eff) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                rem[i] = slot_q[i + 1];
            end
            rem[DEPTH-1] = '0;
        end

        // place[i]: new literal lands at or below slot i. Strict '>' keeps
        // equal indices in arrival order. The vector is thermometer-shaped
        // because the remainder is sorted.
        for (int i = 0; i < DEPTH; i++) begin
            place[i]      = !(CNT_W'(i) < count_rem) ||
                            (lit_var(rem[i]) > lit_var(new_lit));
            valid_next[i] = CNT_W'(i) < count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            lit_t w_lower;
            lit_t w_upper;
            logic w_place_lower;

            if (gi == 0) begin : g_first
                assign w_lower       = '0;
                assign w_place_lower = 1'b0;
            end else begin : g_inner_lo
                assign w_lower       = slot_q[gi-1];
                assign w_place_lower = place[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_last
                assign w_upper = '0;
            end else begin : g_inner_hi
                assign w_upper = slot_q[gi+1];
            end

            uc_insert_slot u_slot (
                .slot_own_i    (slot_q[gi]),
                .slot_lower_i  (w_lower),
                .slot_upper_i  (w_upper),
                .new_lit_i     (new_lit),
                .pop_i         (pop_eff),
                .ins_i         (ins_en),
                .place_self_i  (place[gi]),
                .place_lower_i (w_place_lower),
                .valid_next_i  (valid_next[gi]),
                .slot_o        (slot_d[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef UCQ_DEDUP_EN
            conflict_q <= 1'b0;
`endif
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef UCQ_DEDUP_EN
            conflict_q <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q    <= count_d;
            overflow_q <= overflow_q | drop_full;
`ifdef UCQ_DEDUP_EN
            conflict_q <= conflict_q | dup_conf;
`endif
        end
    end

    assign eng2uca_min   = slot_q[0];
    assign eng2uca_valid = (count_q != '0);
    assign eng2uca_empty = (count_q == '0);
    assign q_full        = (count_q == CNT_W'(DEPTH));
    assign q_count       = count_q;
    assign overflow      = overflow_q;
`ifdef UCQ_DEDUP_EN
    assign conflict      = conflict_q;
`else
    assign conflict      = 1'b0;
`endif

endmodule
`default_nettype wire
